// File: rtl/cm3_codemux_pkg.sv
// rtl/cm3_codemux_pkg.sv - shared types and AHB-Lite constants for the code-bus arbiter
package cm3_codemux_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic        write;
    } addr_phase_t;

endpackage

// File: rtl/cm3_codemux_arbiter_if.sv
// rtl/cm3_codemux_arbiter_if.sv - one AHB-Lite bus segment (master or memory side)
interface cm3_codemux_arbiter_if;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;

    modport master (
        output HTRANS, HSIZE, HBURST, HPROT, HADDR, HWRITE, HWDATA,
        input  HREADY, HRDATA, HRESP
    );

    modport slave (
        input  HTRANS, HSIZE, HBURST, HPROT, HADDR, HWRITE, HWDATA,
        output HREADY, HRDATA, HRESP
    );
endinterface

// File: rtl/cm3_codemux_holdreg.sv
// rtl/cm3_codemux_holdreg.sv - pending address-phase register for one master
module cm3_codemux_holdreg
    import cm3_codemux_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        clear,
    input  addr_phase_t d,
    output logic        valid,
    output addr_phase_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (capture) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cm3_codemux_arbiter.sv
// rtl/cm3_codemux_arbiter.sv - ICode/DCode to code-memory AHB-Lite arbiter; CM3_CODEMUX_FAIR_EN adds I-starvation bound
module cm3_codemux_arbiter
    import cm3_codemux_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    cm3_codemux_arbiter_if.slave          bus_i,
    cm3_codemux_arbiter_if.slave          bus_d,
    cm3_codemux_arbiter_if.master         bus_m
);

    owner_t      owner, owner_nxt;
    addr_phase_t live_i, live_d, pend_i, pend_d, src_i, src_d, fwd;
    logic        pend_i_vld, pend_d_vld;
    logic        ready_i, ready_d;
    logic        req_i, req_d, src_i_vld, src_d_vld, slot;
    logic        grant_i, grant_d;

    assign live_i = '{addr: bus_i.HADDR, size: bus_i.HSIZE, prot: bus_i.HPROT, write: 1'b0};
    assign live_d = '{addr: bus_d.HADDR, size: bus_d.HSIZE, prot: bus_d.HPROT, write: bus_d.HWRITE};

    // BUSY/IDLE never count as requests; a master stalled by its own pending entry cannot request
    assign req_i = !HRESET && bus_i.HTRANS[1] && ready_i;
    assign req_d = !HRESET && bus_d.HTRANS[1] && ready_d;

    assign src_i_vld = pend_i_vld || req_i;
    assign src_d_vld = pend_d_vld || req_d;
    assign src_i     = pend_i_vld ? pend_i : live_i;
    assign src_d     = pend_d_vld ? pend_d : live_d;
    assign slot      = bus_m.HREADY && !HRESET;

`ifdef CM3_CODEMUX_FAIR_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;
    logic          i_first;

    assign i_first = (starve_cnt == CW'(STARVE_LIMIT));
    assign grant_i = slot && src_i_vld && (i_first || !src_d_vld);
    assign grant_d = slot && src_d_vld && !grant_i;

    always_ff @(posedge HCLK) begin
        if (HRESET || grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && pend_i_vld && !i_first) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (STARVE_LIMIT > 0);
    assign grant_d    = slot && src_d_vld;
    assign grant_i    = slot && src_i_vld && !src_d_vld;
`endif

    cm3_codemux_holdreg u_hold_i (
        .clk     (HCLK),
        .rst     (HRESET),
        .capture (req_i && !grant_i),
        .clear   (grant_i && pend_i_vld),
        .d       (live_i),
        .valid   (pend_i_vld),
        .q       (pend_i)
    );

    cm3_codemux_holdreg u_hold_d (
        .clk     (HCLK),
        .rst     (HRESET),
        .capture (req_d && !grant_d),
        .clear   (grant_d && pend_d_vld),
        .d       (live_d),
        .valid   (pend_d_vld),
        .q       (pend_d)
    );

    always_comb begin
        fwd = '0;
        if (grant_d) begin
            fwd = src_d;
        end else if (grant_i) begin
            fwd = src_i;
        end
    end

    assign bus_m.HTRANS = (grant_d || grant_i) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus_m.HBURST = HBURST_SINGLE;
    assign bus_m.HADDR  = fwd.addr;
    assign bus_m.HSIZE  = fwd.size;
    assign bus_m.HPROT  = fwd.prot;
    assign bus_m.HWRITE = fwd.write;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_nxt;
        end
    end

    always_comb begin
        owner_nxt = owner;
        if (bus_m.HREADY) begin
            if (grant_d) begin
                owner_nxt = OWN_D;
            end else if (grant_i) begin
                owner_nxt = OWN_I;
            end else begin
                owner_nxt = OWN_NONE;
            end
        end
    end

    always_comb begin
        ready_i = ((owner == OWN_I) ? bus_m.HREADY : 1'b1) && !pend_i_vld;
        ready_d = ((owner == OWN_D) ? bus_m.HREADY : 1'b1) && !pend_d_vld;
        bus_i.HREADY = ready_i;
        bus_d.HREADY = ready_d;
        bus_i.HRDATA = (owner == OWN_I) ? bus_m.HRDATA : 32'h0;
        bus_d.HRDATA = (owner == OWN_D) ? bus_m.HRDATA : 32'h0;
        bus_i.HRESP  = (owner == OWN_I) ? bus_m.HRESP : HRESP_OKAY;
        bus_d.HRESP  = (owner == OWN_D) ? bus_m.HRESP : HRESP_OKAY;
        bus_m.HWDATA = (owner == OWN_D) ? bus_d.HWDATA : 32'h0;
    end

    logic unused_bits;
    assign unused_bits = ^{bus_i.HWRITE, bus_i.HWDATA, bus_i.HBURST, bus_d.HBURST,
                           bus_i.HTRANS[0], bus_d.HTRANS[0]};

endmodule

// File: tb/tb_cm3_codemux_arbiter.sv
// tb/tb_cm3_codemux_arbiter.sv - directed vector bench for the code-bus arbiter
module tb_cm3_codemux_arbiter;
    import cm3_codemux_pkg::*;

    localparam logic [1:0] N = HTRANS_NONSEQ;
    localparam logic [1:0] E = HRESP_ERROR;
    localparam int NV = 22;
    localparam int NS = 10;

    typedef struct packed {
        logic [1:0]  ti;  logic [31:0] ai;
        logic [1:0]  td;  logic [31:0] ad;  logic wd;  logic [31:0] dd;
        logic        rm;  logic [31:0] dm;  logic [1:0] em;
        logic [1:0]  tm;  logic [31:0] am;  logic wm;  logic [31:0] wdm;
        logic        ri;  logic rd;
        logic [31:0] di;  logic [31:0] ddo;
        logic [1:0]  ei;  logic [1:0] ed;
    } vec_t;

    logic HCLK;
    logic HRESET;
    int   n_checks;
    int   n_fail;

    cm3_codemux_arbiter_if if_i ();
    cm3_codemux_arbiter_if if_d ();
    cm3_codemux_arbiter_if if_m ();

    cm3_codemux_arbiter #(.STARVE_LIMIT(4)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus_i  (if_i),
        .bus_d  (if_d),
        .bus_m  (if_m)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        if_i.HTRANS = v.ti;  if_i.HADDR = v.ai;
        if_d.HTRANS = v.td;  if_d.HADDR = v.ad;  if_d.HWRITE = v.wd;  if_d.HWDATA = v.dd;
        if_m.HREADY = v.rm;  if_m.HRDATA = v.dm; if_m.HRESP = v.em;
    endtask

    vec_t vt[NV];
    logic [31:0] st_am[NS];
    logic        st_ri[NS];
    logic        st_rd[NS];
    logic [31:0] d_addr;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        //     ti ai        td dd-addr    wd dd            rm dm            em | tm am        wm wdm           ri rd di            ddo           ei ed
        vt[0]  = '{0, 32'h0,   0, 32'h0,   0, 32'h0,        1, 32'h0,        0,   0, 32'h0,   0, 32'h0,        1, 1, 32'h0,        32'h0,        0, 0};
        vt[1]  = '{N, 32'h100, 0, 32'h0,   0, 32'h0,        1, 32'h0,        0,   N, 32'h100, 0, 32'h0,        1, 1, 32'h0,        32'h0,        0, 0};
        vt[2]  = '{0, 32'h0,   0, 32'h0,   0, 32'h0,        1, 32'hDEADBEEF, 0,   0, 32'h0,   0, 32'h0,        1, 1, 32'hDEADBEEF, 32'h0,        0, 0};
        vt[3]  = '{N, 32'h200, N, 32'h300, 0, 32'h0,        1, 32'h0,        0,   N, 32'h300, 0, 32'h0,        1, 1, 32'h0,        32'h0,        0, 0};
        vt[4]  = '{0, 32'h0,   0, 32'h0,   0, 32'h0,        1, 32'hAAAA0001, 0,   N, 32'h200, 0, 32'h0,        0, 1, 32'h0,        32'hAAAA0001, 0, 0};
        vt[5]  = '{0, 32'h0,   0, 32'h0,   0, 32'h0,        1, 32'hBBBB0002, 0,   0, 32'h0,   0, 32'h0,        1, 1, 32'hBBBB0002, 32'h0,        0, 0};
        vt[6]  = '{0, 32'h0,   N, 32'h400, 1, 32'h12345678, 1, 32'h0,        0,   N, 32'h400, 1, 32'h0,        1, 1, 32'h0,        32'h0,        0, 0};
        vt[7]  = '{0, 32'h0,   0, 32'h0,   0, 32'h12345678, 0, 32'h0,        0,   0, 32'h0,   0, 32'h12345678, 1, 0, 32'h0,        32'h0,        0, 0};
        vt[8]  = '{0, 32'h0,   0, 32'h0,   0, 32'h12345678, 0, 32'h0,        0,   0, 32'h0,   0, 32'h12345678, 1, 0, 32'h0,        32'h0,        0, 0};
        vt[9]  = '{0, 32'h0,   0, 32'h0,   0, 32'h12345678, 1, 32'h0,        0,   0, 32'h0,   0, 32'h12345678, 1, 1, 32'h0,        32'h0,        0, 0};
        vt[10] = '{0, 32'h0,   0, 32'h0,   0, 32'h0,        1, 32'h0,        0,   0, 32'h0,   0, 32'h0,        1, 1, 32'h0,        32'h0,        0, 0};
        vt[11] = '{N, 32'h500, 0, 32'h0,   0, 32'h0,        1, 32'h0,        0,   N, 32'h500, 0, 32'h0,        1, 1, 32'h0,        32'h0,        0, 0};
        vt[12] = '{0, 32'h0,   0, 32'h0,   0, 32'h0,        0, 32'h0,        E,   0, 32'h0,   0, 32'h0,        0, 1, 32'h0,        32'h0,        E, 0};
        vt[13] = '{0, 32'h0,   0, 32'h0,   0, 32'h0,        1, 32'h0,        E,   0, 32'h0,   0, 32'h0,        1, 1, 32'h0,        32'h0,        E, 0};
        vt[14] = '{0, 32'h0,   0, 32'h0,   0, 32'h0,        1, 32'h0,        0,   0, 32'h0,   0, 32'h0,        1, 1, 32'h0,        32'h0,        0, 0};
        vt[15] = '{0, 32'h0,   N, 32'h600, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0,   0, 32'h0,        1, 1, 32'h0,        32'h0,        0, 0};
        vt[16] = '{0, 32'h0,   0, 32'h0,   0, 32'h0,        1, 32'h0,        0,   N, 32'h600, 0, 32'h0,        1, 0, 32'h0,        32'h0,        0, 0};
        vt[17] = '{0, 32'h0,   0, 32'h0,   0, 32'h0,        1, 32'hCCCC0003, 0,   0, 32'h0,   0, 32'h0,        1, 1, 32'h0,        32'hCCCC0003, 0, 0};
        vt[18] = '{N, 32'h700, 0, 32'h0,   0, 32'h0,        1, 32'h0,        0,   N, 32'h700, 0, 32'h0,        1, 1, 32'h0,        32'h0,        0, 0};
        vt[19] = '{N, 32'h704, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0,   0, 32'h0,   0, 32'h0,        0, 1, 32'h0,        32'h0,        0, 0};
        vt[20] = '{N, 32'h704, 0, 32'h0,   0, 32'h0,        1, 32'h11110001, 0,   N, 32'h704, 0, 32'h0,        1, 1, 32'h11110001, 32'h0,        0, 0};
        vt[21] = '{0, 32'h0,   0, 32'h0,   0, 32'h0,        1, 32'h11110002, 0,   0, 32'h0,   0, 32'h0,        1, 1, 32'h11110002, 32'h0,        0, 0};

`ifdef CM3_CODEMUX_FAIR_EN
        st_am = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h800, 32'h1014, 32'h1018, 32'h0, 32'h0};
        st_ri = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        st_rd = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
`else
        st_am = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h1014, 32'h1018, 32'h101C, 32'h800, 32'h0};
        st_ri = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        st_rd = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif

        if_i.HSIZE = 3'd2;  if_i.HPROT = 4'h3;  if_i.HBURST = 3'd0;
        if_i.HWRITE = 1'b0; if_i.HWDATA = 32'h0;
        if_d.HSIZE = 3'd2;  if_d.HPROT = 4'h3;  if_d.HBURST = 3'd0;

        // reset held two edges while I is asking for a transfer
        HRESET = 1'b1;
        drive('{N, 32'h100, 0, 32'h0, 0, 32'h0, 1, 32'h0, 0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h0, 32'h0, 0, 0});
        @(negedge HCLK);
        #2;
        chk("rst_htransm", 32'(if_m.HTRANS), 32'(HTRANS_IDLE));
        chk("rst_haddrm",  if_m.HADDR, 32'h0);
        chk("rst_hreadyi", 32'(if_i.HREADY), 32'h1);
        chk("rst_hreadyd", 32'(if_d.HREADY), 32'h1);
        chk("rst_hrespi",  32'(if_i.HRESP), 32'h0);
        chk("rst_hrespd",  32'(if_d.HRESP), 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        drive(vt[0]);

        for (int k = 0; k < NV; k++) begin
            @(negedge HCLK);
            drive(vt[k]);
            #2;
            chk($sformatf("v%0d_htransm", k), 32'(if_m.HTRANS), 32'(vt[k].tm));
            chk($sformatf("v%0d_haddrm", k),  if_m.HADDR, vt[k].am);
            chk($sformatf("v%0d_hsizem", k),  32'(if_m.HSIZE), vt[k].tm[1] ? 32'd2 : 32'd0);
            chk($sformatf("v%0d_hprotm", k),  32'(if_m.HPROT), vt[k].tm[1] ? 32'h3 : 32'h0);
            chk($sformatf("v%0d_hburstm", k), 32'(if_m.HBURST), 32'(HBURST_SINGLE));
            chk($sformatf("v%0d_hwritem", k), 32'(if_m.HWRITE), 32'(vt[k].wm));
            chk($sformatf("v%0d_hwdatam", k), if_m.HWDATA, vt[k].wdm);
            chk($sformatf("v%0d_hreadyi", k), 32'(if_i.HREADY), 32'(vt[k].ri));
            chk($sformatf("v%0d_hreadyd", k), 32'(if_d.HREADY), 32'(vt[k].rd));
            chk($sformatf("v%0d_hrdatai", k), if_i.HRDATA, vt[k].di);
            chk($sformatf("v%0d_hrdatad", k), if_d.HRDATA, vt[k].ddo);
            chk($sformatf("v%0d_hrespi", k),  32'(if_i.HRESP), 32'(vt[k].ei));
            chk($sformatf("v%0d_hrespd", k),  32'(if_d.HRESP), 32'(vt[k].ed));
        end

        // D streams NONSEQ for 8 cycles while one I request waits behind it
        d_addr = 32'h1000;
        for (int c = 0; c < NS; c++) begin
            @(negedge HCLK);
            if_i.HTRANS = (c == 0) ? N : HTRANS_IDLE;
            if_i.HADDR  = 32'h800;
            if_d.HTRANS = (c < 8) ? N : HTRANS_IDLE;
            if_d.HADDR  = d_addr;
            if_d.HWRITE = 1'b0;
            if_d.HWDATA = 32'h0;
            if_m.HREADY = 1'b1;
            if_m.HRDATA = 32'h0;
            if_m.HRESP  = HRESP_OKAY;
            #2;
            chk($sformatf("starve%0d_haddrm", c),  if_m.HADDR, st_am[c]);
            chk($sformatf("starve%0d_hreadyi", c), 32'(if_i.HREADY), 32'(st_ri[c]));
            chk($sformatf("starve%0d_hreadyd", c), 32'(if_d.HREADY), 32'(st_rd[c]));
            if (c < 8 && if_d.HREADY) d_addr = d_addr + 32'h4;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
